// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core load/store path vs debug/loader port.
// Core has priority; a starvation counter forces a debug grant.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wmask,
  output logic                core_stall,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rvalid,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_wmask,
  output logic                dbg_gnt,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_rvalid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LW = $clog2(MEM_LAT + 2);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_END = LW'(MEM_LAT);
  localparam logic [SW-1:0] S_MAX   = SW'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic dbg_win;
  logic core_win;
  logic done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_CORE;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration only happens in IDLE; reset masks every strobe.
  always_comb begin
    dbg_win  = 1'b0;
    core_win = 1'b0;
    done     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          dbg_win  = dbg_req & (!core_req | (starve_q == S_MAX));
          core_win = core_req & !dbg_win;
        end
        BUSY: done = (lat_q == LAT_END);
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = dbg_win | core_win;
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_wmask = core_wmask;
    if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wmask = dbg_wmask;
    end else if (core_win) begin
      mem_we    = core_we;
    end
  end

  assign dbg_gnt     = dbg_win;
  assign core_rvalid = done & (owner_q == OWN_CORE);
  assign dbg_rvalid  = done & (owner_q == OWN_DBG);
  assign core_rdata  = mem_rdata;
  assign dbg_rdata   = mem_rdata;
  assign core_stall  = !rst & core_req
                     & !((core_win & core_we) | core_rvalid);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (dbg_win && !dbg_we) begin
          state_d = BUSY;
          owner_d = OWN_DBG;
          lat_d   = LW'(1);
        end else if (core_win && !core_we) begin
          state_d = BUSY;
          owner_d = OWN_CORE;
          lat_d   = LW'(1);
        end
      end
      BUSY: begin
        lat_d = lat_q + LW'(1);
        if (done) begin
          state_d = IDLE;
          lat_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Counts core grants that made a waiting debug request wait.
    if (!dbg_req || dbg_win) begin
      starve_d = '0;
    end else if (core_win && (starve_q != S_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between the RISC_V core's load/store path and a debug/loader port. The core has priority; an anti-starvation counter guarantees the debug port a grant. The block stalls the single-cycle core while a core read is in flight or while the core has lost arbitration, and returns read data with a one-cycle valid strobe to whichever requester owns the transaction.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; the byte-mask width is DATA_W/8
MEM_LAT, 1, cycles from read issue to valid mem_rdata; must be ≥1
STARVE_MAX, 4, consecutive core grants allowed while dbg_req is pending before debug is forced

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
core_req  in  1  core memory access request; held stable while core_stall=1
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_wmask  in  DATA_W/8  core byte enables
core_stall  out  1  freeze the core's PC and register writeback
core_rdata  out  DATA_W  core read data
core_rvalid  out  1  core read data valid, one-cycle pulse
dbg_req  in  1  debug request; held until dbg_gnt
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_wmask  in  DATA_W/8  debug byte enables
dbg_gnt  out  1  debug request accepted, one-cycle pulse
dbg_rdata  out  DATA_W  debug read data
dbg_rvalid  out  1  debug read data valid, one-cycle pulse
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- States: IDLE, BUSY. Registered state: owner (CORE/DBG), lat_cnt, starve_cnt.
- Reset, while rst=1: state=IDLE, lat_cnt=0, starve_cnt=0. All strobe and enable outputs are held at 0: mem_en, mem_we, dbg_gnt, core_rvalid, dbg_rvalid, core_stall.
- Reset mid-transaction drops the transaction; no rvalid is ever produced for it.
- IDLE arbitration is combinational in the issue cycle:
  - Debug wins if dbg_req and (!core_req or starve_cnt==STARVE_MAX).
  - Otherwise the core wins if core_req.
  - The winner's signals drive mem_*, with mem_en=1.
- Write grant:
  - Completes in the issue cycle; state stays IDLE.
  - Core winner: core_stall=0. Debug winner: dbg_gnt=1.
- Read grant:
  - Issue cycle N: a debug winner gets dbg_gnt=1; a core winner gets core_stall=1.
  - Next state is BUSY, with owner latched and lat_cnt=1.
- BUSY:
  - mem_en=0 and no new grants.
  - lat_cnt increments each cycle.
  - In cycle N+MEM_LAT the owner's rvalid=1 and rdata=mem_rdata (combinational pass-through). Next state is IDLE.
  - Back-to-back throughput is therefore one read per MEM_LAT+1 cycles.
- core_stall = core_req and not (core write granted this cycle, or core_rvalid this cycle).
  - So a core read stalls cycles N..N+MEM_LAT-1 and releases in the rvalid cycle.
  - A core that lost arbitration or arrives while BUSY stalls.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on every cycle where the core is granted while dbg_req=1.
  - Cleared to 0 on a debug grant or when dbg_req=0.
- core_rdata and dbg_rdata always mirror mem_rdata; only the valids are qualified.
- dbg_gnt is never asserted in BUSY, nor in the same cycle as a core grant.
- Address and mask pass through unchecked; misalignment is the requester's responsibility.

Test Plan:
1. Lone core write (addr 0x10, data 0xDEADBEEF, mask 0xF) → same cycle mem_en=1, mem_we=1, mem_addr=0x10, core_stall=0; state remains IDLE.
2. Core read with MEM_LAT=1, memory returning 0x12345678 → cycle N: core_stall=1, mem_en=1, mem_we=0; cycle N+1: core_rvalid=1, core_rdata=0x12345678, core_stall=0; cycle N+2: IDLE.
3. Core writes every cycle plus a held dbg write → core granted 4 cycles (starve_cnt 1..4); 5th cycle: dbg_gnt=1, core_stall=1, mem_addr=dbg_addr; starve_cnt returns to 0.
4. dbg read raised during a core read's BUSY cycle → dbg_gnt=0 until IDLE, then granted; dbg_rvalid arrives MEM_LAT cycles after dbg_gnt.
5. rst=1 in cycle N+1 of a core read → no core_rvalid; state IDLE; mem_en=0 and core_stall=0 while rst=1.
6. MEM_LAT=3 build, core read → core_stall=1 for cycles N..N+2, core_rvalid=1 at N+3, next issue no earlier than N+4.
